// File: rtl/hex_display_pkg.sv
// Shared seven-segment constants: active-low glyphs for 0-F and the all-off pattern.
// Bit order is {a,b,c,d,e,f,g}, so segment a is the MSB.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t GLYPH [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg
  import hex_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  assign seg_o = GLYPH[hex_i];

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner with frame-synchronous updates, leading-zero blanking,
// per-digit blink, and PWM brightness control.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV_BITS   = 17,
  parameter int unsigned BLINK_BITS = 6
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [4*NUM_DIGITS-1:0] x,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lz_blank,
  input  logic [3:0]              bright,
  input  logic                    load,
  output logic                    ready,
  output logic [6:0]              a_to_g,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  // Update word layout: {x, dp, blink}
  localparam int unsigned UpdW = 6 * NUM_DIGITS;

  logic [DIV_BITS-1:0]   dwell_q, dwell_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BLINK_BITS:0]   frame_q, frame_d;
  logic                  dwell_wrap, frame_edge;

  logic [UpdW-1:0]       pend_q, pend_d, disp_q, disp_d;
  logic                  pend_vld_q, pend_vld_d;

  logic [4*NUM_DIGITS-1:0] disp_x;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_blink, lz_mask;
  logic                    lead, blanked;
  logic [3:0]              cur_hex;
  seg_t                    glyph, seg_d, seg_q;
  logic                    dp_out_d, dp_out_q;
  logic [NUM_DIGITS-1:0]   an_d, an_q;

  assign disp_x     = disp_q[UpdW-1 -: 4*NUM_DIGITS];
  assign disp_dp    = disp_q[2*NUM_DIGITS-1 -: NUM_DIGITS];
  assign disp_blink = disp_q[NUM_DIGITS-1:0];

  always_comb begin
    dwell_wrap = &dwell_q;
    frame_edge = dwell_wrap && (idx_q == LastIdx);
    dwell_d    = dwell_q + 1'b1;
    idx_d      = idx_q;
    if (dwell_wrap) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
    frame_d = frame_edge ? frame_q + 1'b1 : frame_q;
  end

  // A load landing on the frame boundary bypasses pending; otherwise latest load wins.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    disp_d     = disp_q;
    if (frame_edge) begin
      if (load) begin
        disp_d = {x, dp, blink};
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = {x, dp, blink};
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    lz_mask = '0;
    lead    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead       = lead & (disp_x[4*i +: 4] == 4'h0);
      lz_mask[i] = lead && (i != 0);
    end
  end

  assign cur_hex = disp_x[4*idx_q +: 4];

  hex_to_seg u_hex_to_seg (
    .hex_i (cur_hex),
    .seg_o (glyph)
  );

  always_comb begin
    blanked  = (lz_blank && lz_mask[idx_q]) || (disp_blink[idx_q] && frame_q[BLINK_BITS]);
    seg_d    = blanked ? SEG_BLANK : glyph;
    dp_out_d = blanked ? 1'b1 : ~disp_dp[idx_q];
    an_d     = '0;
    // Dark on the last dwell cycle so the enable is low while the index moves on.
    if (!dwell_wrap && (dwell_q[DIV_BITS-1 -: 4] <= bright)) begin
      an_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dwell_q    <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      disp_q     <= '0;
      seg_q      <= SEG_BLANK;
      dp_out_q   <= 1'b1;
      an_q       <= '0;
    end else begin
      dwell_q    <= dwell_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
      dp_out_q   <= dp_out_d;
      an_q       <= an_d;
    end
  end

  assign ready  = ~pend_vld_q;
  assign a_to_g = seg_q;
  assign dp_out = dp_out_q;
  assign an     = an_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: vector table plus scoreboard of per-digit expectations.
module tb_hex_display_scanner;

  localparam int ND    = 4;
  localparam int DB    = 5;
  localparam int BB    = 1;
  localparam int FRAME = ND * (1 << DB);

  localparam logic [6:0] BLK = 7'b1111111;

  logic            clk = 1'b0;
  logic            clr_n;
  logic [4*ND-1:0] x;
  logic [ND-1:0]   dp, blink;
  logic            lz_blank;
  logic [3:0]      bright;
  logic            load;
  logic            ready;
  logic [6:0]      a_to_g;
  logic            dp_out;
  logic [ND-1:0]   an;

  hex_display_scanner #(
    .NUM_DIGITS (ND),
    .DIV_BITS   (DB),
    .BLINK_BITS (BB)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .x        (x),
    .dp       (dp),
    .blink    (blink),
    .lz_blank (lz_blank),
    .bright   (bright),
    .load     (load),
    .ready    (ready),
    .a_to_g   (a_to_g),
    .dp_out   (dp_out),
    .an       (an)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset release; gives the bench the scan phase.
  int unsigned cyc;
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_vec = 0;
  int n_bad = 0;
  logic saw_one;

  typedef struct packed {
    logic [6:0] seg;
    logic       dpo;
    int         on;
  } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic [15:0] x;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  br;
    logic [27:0] segs;  // {d3,d2,d1,d0}
    logic [3:0]  dpo;
    int          on;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpo, input int on);
    for (int i = 0; i < ND; i++) sbq.push_back('{seg: segs[7*i +: 7], dpo: dpo[i], on: on});
  endtask

  task automatic sync_to(input int unsigned ph);
    int k = 0;
    while ((cyc % FRAME) != ph && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_load(input logic [15:0] xv, input logic [3:0] dpv, input logic [3:0] bv);
    if (((cyc + 1) % FRAME) == 0) @(negedge clk);
    x = xv; dp = dpv; blink = bv; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("ready low after load", {31'd0, ready}, 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
      if (an != '0 && a_to_g == 7'b1001111) saw_one = 1'b1;
    end
    chk({tag, " ready rises"}, {31'd0, ready}, 32'd1);
  endtask

  // One full frame: per-digit glyph, dp and lit-cycle count, popped from the scoreboard.
  task automatic observe(input string tag);
    int cnt [ND];
    logic [6:0] seg_s [ND];
    logic dpo_s [ND];
    int unstable = 0;
    int multi = 0;
    exp_t e;
    for (int i = 0; i < ND; i++) begin
      cnt[i] = 0; seg_s[i] = 'x; dpo_s[i] = 1'bx;
    end
    repeat (FRAME) begin
      @(negedge clk);
      if ($countones(an) > 1) multi++;
      for (int i = 0; i < ND; i++) begin
        if (an[i]) begin
          if (cnt[i] == 0) begin
            seg_s[i] = a_to_g; dpo_s[i] = dp_out;
          end else if (a_to_g !== seg_s[i] || dp_out !== dpo_s[i]) begin
            unstable++;
          end
          cnt[i]++;
        end
      end
    end
    chk({tag, " an one-hot"}, multi, 0);
    chk({tag, " steady digits"}, unstable, 0);
    for (int i = 0; i < ND; i++) begin
      if (sbq.size() == 0) begin
        chk({tag, " scoreboard underrun"}, 1, 0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("%s d%0d seg", tag, i), {25'd0, seg_s[i]}, {25'd0, e.seg});
        chk($sformatf("%s d%0d dp_out", tag, i), {31'd0, dpo_s[i]}, {31'd0, e.dpo});
        chk($sformatf("%s d%0d on", tag, i), cnt[i], e.on);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nblank, bad0, badx, k;

    vecs[0] = '{x: 16'h12AF, dp: 4'h0, lz: 1'b0, br: 4'd15,
                segs: {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, dpo: 4'hF, on: 31};
    vecs[1] = '{x: 16'h0030, dp: 4'h0, lz: 1'b1, br: 4'd7,
                segs: {BLK, BLK, 7'b0000110, 7'b0000001}, dpo: 4'hF, on: 16};
    vecs[2] = '{x: 16'h0000, dp: 4'hF, lz: 1'b1, br: 4'd0,
                segs: {BLK, BLK, BLK, 7'b0000001}, dpo: 4'b1110, on: 2};
    vecs[3] = '{x: 16'h8C5E, dp: 4'b0101, lz: 1'b1, br: 4'd3,
                segs: {7'b0000000, 7'b0110001, 7'b0100100, 7'b0110000}, dpo: 4'b1010, on: 8};
    vecs[4] = '{x: 16'h0B09, dp: 4'b1000, lz: 1'b1, br: 4'd11,
                segs: {BLK, 7'b1100000, 7'b0000001, 7'b0000100}, dpo: 4'hF, on: 24};
    vecs[5] = '{x: 16'h7D64, dp: 4'b0010, lz: 1'b0, br: 4'd15,
                segs: {7'b0001111, 7'b1000010, 7'b0100000, 7'b1001100}, dpo: 4'b1101, on: 31};

    x = '0; dp = '0; blink = '0; lz_blank = 1'b0; bright = 4'd15; load = 1'b0; saw_one = 1'b0;
    clr_n = 1'b0;
    #12;
    chk("reset an", {28'd0, an}, 32'd0);
    chk("reset a_to_g", {25'd0, a_to_g}, 32'h7F);
    chk("reset dp_out", {31'd0, dp_out}, 32'd1);
    chk("reset ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    clr_n = 1'b1;

    // Load presented on the frame-boundary cycle goes straight to the display.
    k = 0;
    while (cyc != FRAME - 1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    x = 16'h5A3C; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("boundary load keeps ready", {31'd0, ready}, 32'd1);
    x = 16'hFFFF;  // no load: must stay invisible
    push_frame({7'b0100100, 7'b0001000, 7'b0000110, 7'b0110001}, 4'hF, 31);
    observe("bndry");

    for (int v = 0; v < 6; v++) begin
      lz_blank = vecs[v].lz;
      bright   = vecs[v].br;
      do_load(vecs[v].x, vecs[v].dp, 4'h0);
      wait_ready($sformatf("vec%0d", v));
      repeat (2) @(negedge clk);
      push_frame(vecs[v].segs, vecs[v].dpo, vecs[v].on);
      observe($sformatf("vec%0d", v));
    end

    // Two loads within one frame: only the latest may ever reach the display.
    lz_blank = 1'b0; bright = 4'd15; saw_one = 1'b0;
    sync_to(10);
    do_load(16'h1111, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("ready held before 2nd load", {31'd0, ready}, 32'd0);
    do_load(16'h2222, 4'h0, 4'h0);
    wait_ready("latest");
    chk("stale 1111 never shown", {31'd0, saw_one}, 32'd0);
    repeat (2) @(negedge clk);
    push_frame({4{7'b0010010}}, 4'hF, 31);
    observe("latest");

    // Blink on digit 0: blank in frames 2,3 of every 4 since reset.
    do_load(16'h8888, 4'h0, 4'b0001);
    wait_ready("blink");
    repeat (2) @(negedge clk);
    nblank = 0; bad0 = 0; badx = 0;
    repeat (4 * FRAME) begin
      @(negedge clk);
      if (an[0]) begin
        if ((a_to_g == BLK) != ((((cyc - 1) / FRAME) % 4) >= 2)) bad0++;
        if (a_to_g == BLK) nblank++;
      end
      if (an[ND-1:1] != '0 && a_to_g != 7'b0000000) badx++;
    end
    chk("blink d0 phase errors", bad0, 0);
    chk("blink d0 blank cycles", nblank, 62);
    chk("blink other digits steady", badx, 0);

    // Reset mid-dwell with an update pending.
    blink = '0;
    sync_to(20);
    do_load(16'h5555, 4'h0, 4'h0);
    repeat (5) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("async reset an", {28'd0, an}, 32'd0);
    chk("async reset a_to_g", {25'd0, a_to_g}, 32'h7F);
    chk("async reset dp_out", {31'd0, dp_out}, 32'd1);
    chk("async reset ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    clr_n = 1'b1;
    k = 0;
    while (an == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("scan restarts at digit 0", {28'd0, an}, 32'd1);
    chk("ready after reset", {31'd0, ready}, 32'd1);
    push_frame({4{7'b0000001}}, 4'hF, 31);
    observe("post-reset");
    chk("pending discarded", {31'd0, ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
